// File: rtl/instruction_aligner_pkg.sv
// Shared types for the fetch-side instruction aligner: instruction/halfword
// containers, the fetch FSM encoding and the halfword queue geometry.
package instruction_aligner_pkg;

  typedef logic [31:0] instruction_type;
  typedef logic [15:0] halfword_type;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_DROP
  } fetch_state_t;

  localparam int unsigned QUEUE_DEPTH = 4;

  // RV32C: any low-bit pattern other than 2'b11 marks a 16-bit instruction.
  function automatic logic is_compressed(input halfword_type hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/instruction_aligner_halfword_queue.sv
// 4-entry circular FIFO of halfwords; pushes and pops of 0, 1 or 2 entries
// per cycle, with the two oldest entries exposed for instruction decode.
module instruction_aligner_halfword_queue
  import instruction_aligner_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [1:0]   push_n,
  input  halfword_type push_data0,
  input  halfword_type push_data1,
  input  logic [1:0]   pop_n,
  output halfword_type head0,
  output halfword_type head1,
  output logic [2:0]   count
);

  halfword_type entries [QUEUE_DEPTH];
  logic [1:0]   rd_ptr;
  logic [1:0]   wr_ptr;

  assign head0 = entries[rd_ptr];
  assign head1 = entries[rd_ptr + 2'd1];

  // Callers never push past capacity, so writes only land in free slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < QUEUE_DEPTH; i++) entries[i] <= '0;
    end else if (clear) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_n != 2'd0) entries[wr_ptr] <= push_data0;
      if (push_n == 2'd2) entries[wr_ptr + 2'd1] <= push_data1;
      wr_ptr <= wr_ptr + push_n;
      rd_ptr <= rd_ptr + pop_n;
      count  <= count + {1'b0, push_n} - {1'b0, pop_n};
    end
  end

endmodule

// File: rtl/instruction_aligner.sv
// Fetch-side aligner: requests words from program memory, splits them into
// halfwords and hands whole 16/32-bit instructions with their PC downstream.
module instruction_aligner
  import instruction_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  output logic            mem_req,
  output logic [31:0]     mem_addr,
  input  logic            mem_valid,
  input  logic [31:0]     mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output instruction_type out_instr,
  output logic [31:0]     out_pc,
  output logic            out_is_compressed,
  output fetch_state_t    dbg_state,
  output logic [2:0]      dbg_count
);

  fetch_state_t state, state_next;
  logic [31:0]  fetch_addr;
  logic [31:0]  pc;
  logic         skip_half;
  logic         active;

  halfword_type head0, head1, push_data0, push_data1;
  logic [2:0]   count, count_after_pop, count_after;
  logic [1:0]   push_n, pop_n;
  logic         head_comp, instr_avail, fire, resp;

  instruction_aligner_halfword_queue u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (redirect),
    .push_n     (push_n),
    .push_data0 (push_data0),
    .push_data1 (push_data1),
    .pop_n      (pop_n),
    .head0      (head0),
    .head1      (head1),
    .count      (count)
  );

  // Output handshake: an instruction transfers on a cycle where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and the
  // offered instruction and PC hold steady until that transfer happens.
  assign head_comp         = is_compressed(head0);
  assign instr_avail       = head_comp ? (count != 3'd0) : (count >= 3'd2);
  assign out_valid         = instr_avail && !redirect;
  assign out_is_compressed = instr_avail && head_comp;
  assign out_instr         = !instr_avail ? '0 :
                             head_comp ? {16'h0000, head0} : {head1, head0};
  assign out_pc            = pc;
  assign fire              = out_valid && out_ready;
  assign pop_n             = !fire ? 2'd0 : (head_comp ? 2'd1 : 2'd2);

  // A response in F_WAIT belongs to us; during a redirect it is discarded.
  assign resp            = (state == F_WAIT) && mem_valid;
  assign push_n          = (resp && !redirect) ? (skip_half ? 2'd1 : 2'd2) : 2'd0;
  assign push_data0      = skip_half ? mem_rdata[31:16] : mem_rdata[15:0];
  assign push_data1      = mem_rdata[31:16];
  assign count_after_pop = count - {1'b0, pop_n};
  assign count_after     = count_after_pop + {1'b0, push_n};

  // A back-to-back request goes out at the address after the word arriving now.
  assign mem_addr  = resp ? fetch_addr + 32'd4 : fetch_addr;
  assign dbg_state = state;
  assign dbg_count = count;

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    if (redirect) begin
      case (state)
        F_WAIT:  state_next = mem_valid ? F_IDLE : F_DROP;
        F_DROP:  state_next = mem_valid ? F_IDLE : F_DROP;
        default: state_next = F_IDLE;
      endcase
    end else begin
      case (state)
        F_IDLE: begin
          if (active && count_after_pop <= 3'd2) begin
            mem_req    = 1'b1;
            state_next = F_WAIT;
          end
        end
        F_WAIT: begin
          if (mem_valid) begin
            if (count_after <= 3'd2) mem_req = 1'b1;
            else                     state_next = F_IDLE;
          end
        end
        F_DROP:  if (mem_valid) state_next = F_IDLE;
        default: state_next = F_IDLE;
      endcase
    end
  end

  // active keeps mem_req low while reset is held and for the release cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= F_IDLE;
      fetch_addr <= RESET_PC & ~32'h3;
      pc         <= RESET_PC & ~32'h1;
      skip_half  <= RESET_PC[1];
      active     <= 1'b0;
    end else begin
      state  <= state_next;
      active <= 1'b1;
      if (redirect) begin
        pc         <= redirect_pc & ~32'h1;
        fetch_addr <= redirect_pc & ~32'h3;
        skip_half  <= redirect_pc[1];
      end else begin
        if (fire) pc <= pc + (head_comp ? 32'd2 : 32'd4);
        if (resp) begin
          fetch_addr <= fetch_addr + 32'd4;
          skip_half  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_aligner.sv
// Directed bench for instruction_aligner: a program-memory model with
// configurable latency, expected-instruction scoreboard and a handshake monitor.
module tb_instruction_aligner;
  import instruction_aligner_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            redirect = 1'b0;
  logic [31:0]     redirect_pc = '0;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic            mem_valid = 1'b0;
  logic [31:0]     mem_rdata = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  instruction_type out_instr;
  logic [31:0]     out_pc;
  logic            out_is_compressed;
  fetch_state_t    dbg_state;
  logic [2:0]      dbg_count;

  instruction_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_valid         (mem_valid),
    .mem_rdata         (mem_rdata),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_instr         (out_instr),
    .out_pc            (out_pc),
    .out_is_compressed (out_is_compressed),
    .dbg_state         (dbg_state),
    .dbg_count         (dbg_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] req_log[$];
  logic [63:0] exp_q[$];
  logic [31:0] prog [logic [31:0]];
  int          cyc = 0;
  int          extra_lat = 0;
  bit          ready_en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  req_t        rsp_r, req_r;
  logic [63:0] mon_e;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return 32'h4501_4501;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp_r     = pend.pop_front();
      mem_valid = 1'b1;
      mem_rdata = rsp_r.data;
    end else begin
      mem_valid = 1'b0;
      mem_rdata = '0;
    end
    out_ready = ready_en && (exp_q.size() > 0);
  end

  always @(negedge clk) begin
    if (mem_req) begin
      req_r.addr = mem_addr;
      req_r.data = word_at(mem_addr);
      req_r.due  = cyc + 1 + extra_lat;
      pend.push_back(req_r);
      req_log.push_back(mem_addr);
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_xfer: got instr %h pc %h expected none", out_instr, out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_instr", out_instr, mon_e[63:32]);
        check("out_pc", out_pc, mon_e[31:0]);
        check("out_is_compressed", {31'b0, out_is_compressed}, {31'b0, mon_e[33:32] != 2'b11});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    pend.delete();
    req_log.delete();
    @(negedge clk);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_is_comp", {31'b0, out_is_compressed}, 32'd0);
    check("rst_count", {29'b0, dbg_count}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, F_IDLE});
    @(posedge clk); #2;
    reset_n = 1'b1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    check("wait_req", {31'b0, mem_req}, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk); #2;
    redirect    = 1'b1;
    redirect_pc = pc;
    @(negedge clk);
    check("redir_no_req", {31'b0, mem_req}, 32'd0);
    check("redir_no_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #2;
    redirect = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_left", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // 1: single 32-bit addi, first-request timing and latency
    prog.delete();
    prog[32'h0] = 32'h0041_0513;
    extra_lat = 0;
    ready_en  = 1'b1;
    exp_q.push_back({32'h0041_0513, 32'h0});
    do_reset();
    @(negedge clk); check("pre_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk); check("first_req", {31'b0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
    @(negedge clk); check("lat_wait", {31'b0, out_valid}, 32'd0);
    @(negedge clk); check("lat_valid", {31'b0, out_valid}, 32'd1);
    wait_drain();
    check("next_addr", req_log[1], 32'h4);

    // 2: two compressed c.li in one word
    prog.delete();
    prog[32'h0] = 32'h4501_4505;
    exp_q.push_back({32'h0000_4505, 32'h0});
    exp_q.push_back({32'h0000_4501, 32'h2});
    do_reset();
    wait_drain();

    // 3: 32-bit instruction straddling a word boundary, slow memory
    prog.delete();
    prog[32'h0] = 32'h0513_4505;
    prog[32'h4] = 32'h4509_0041;
    extra_lat = 4;
    exp_q.push_back({32'h0000_4505, 32'h0});
    exp_q.push_back({32'h0041_0513, 32'h2});
    exp_q.push_back({32'h0000_4509, 32'h6});
    do_reset();
    repeat (10) @(negedge clk);
    check("straddle_hold", {31'b0, out_valid}, 32'd0);
    check("straddle_count", {29'b0, dbg_count}, 32'd1);
    wait_drain();

    // 4: redirect to a halfword-offset target while a request is in flight
    prog.delete();
    prog[32'h0]   = 32'h0001_0001;
    prog[32'h100] = 32'h4509_0513;
    prog[32'h104] = 32'h4501_450d;
    extra_lat = 3;
    exp_q.push_back({32'h0000_4509, 32'h102});
    exp_q.push_back({32'h0000_450d, 32'h104});
    exp_q.push_back({32'h0000_4501, 32'h106});
    do_reset();
    wait_req();
    do_redirect(32'h0000_0103);
    @(negedge clk); check("redir_drop_state", {30'b0, dbg_state}, {30'b0, F_DROP});
    wait_drain();
    check("redir_addr", req_log[1], 32'h100);

    // 5: back-pressure on a compressed stream
    prog.delete();
    prog[32'h0] = 32'h4505_4501;
    prog[32'h4] = 32'h4509_450d;
    extra_lat = 0;
    ready_en  = 1'b0;
    exp_q.push_back({32'h0000_4501, 32'h0});
    exp_q.push_back({32'h0000_4505, 32'h2});
    exp_q.push_back({32'h0000_450d, 32'h4});
    exp_q.push_back({32'h0000_4509, 32'h6});
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_instr", out_instr, 32'h0000_4501);
      check("bp_pc", out_pc, 32'h0);
      check("bp_no_req", {31'b0, mem_req}, 32'd0);
      check("bp_count", {29'b0, dbg_count}, 32'd4);
    end
    check("bp_req_total", req_log.size(), 32'd2);
    ready_en = 1'b1;
    wait_drain();

    // 6: reset while waiting; the stale response lands after release
    prog.delete();
    prog[32'h0]  = 32'h0041_0513;
    prog[32'h40] = 32'h0001_0001;
    extra_lat = 4;
    ready_en  = 1'b1;
    do_reset();
    wait_req();
    do_redirect(32'h0000_0040);
    for (int i = 0; i < 30 && req_log.size() < 2; i++) @(negedge clk);
    check("rst6_redir_addr", req_log[1], 32'h40);
    @(posedge clk); #2;
    reset_n   = 1'b0;
    extra_lat = 0;
    #1;
    check("async_mem_addr", mem_addr, 32'h0);
    check("async_mem_req", {31'b0, mem_req}, 32'd0);
    check("async_state", {30'b0, dbg_state}, {30'b0, F_IDLE});
    exp_q.push_back({32'h0041_0513, 32'h0});
    for (int i = 0; i < 20 && !(pend.size() > 0 && pend[0].due == cyc + 1); i++) begin
      @(posedge clk); #2;
    end
    reset_n = 1'b1;
    @(negedge clk); check("rst6_pre_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk); check("rst6_req", {31'b0, mem_req}, 32'd1);
    check("rst6_addr", mem_addr, 32'h0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
